fft_stage_wr_ctrl: RTL
======================

// Module: fft_stage_wr_ctrl
// PURPOSE
//  Write-side controller for one pipeline FFT stage. Accepts butterfly output
//  pairs (two samples plus their target addresses), serialises them into
//  single-port writes of a ping-pong inter-stage RAM, and counts the samples
//  of each frame. When a bank holds a full frame it hands that bank to the
//  next stage's read controller through a valid/ack handshake.
// PARAMETERS
//  bit_width  29  width of each real/imag sample component
//  N          16  samples per frame (power of 2, >= 4)
//  SIZE       4   address width, log2(N)
// PORTS
//  clk          in   1          clock; all logic on rising edge
//  rst          in   1          synchronous reset, active-high
//  in_valid     in   1          butterfly pair valid; held until accepted
//  in_ready     out  1          pair accepted on cycle where in_valid&&in_ready
//  in_adr1      in   SIZE       RAM address for sample 1
//  in_adr2      in   SIZE       RAM address for sample 2
//  in_re1,in_im1 in  bit_width  sample 1 (signed)
//  in_re2,in_im2 in  bit_width  sample 2 (signed)
//  wr_en        out  1          RAM write strobe
//  wr_bank      out  1          RAM bank being written (0/1)
//  wr_addr      out  SIZE       RAM write address
//  wr_re,wr_im  out  bit_width  RAM write data
//  frm_valid    out  1          bank frm_bank holds a complete frame
//  frm_bank     out  1          bank offered to the next stage
//  frm_ack      in   1          next stage finished reading frm_bank
//  done_o       out  1          one-cycle pulse when a frame completes
//  ovf_err      out  1          sticky: frm_ack seen while frm_valid low
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE, wr_en=0, wr_bank=0, wr_addr=0,
//   wr_re=wr_im=0, cnt=0, bank_full=2'b00, frm_bank=0, frm_valid=0,
//   done_o=0, ovf_err=0, in_ready=0 in the reset cycle. Reset mid-frame drops
//   all buffered data; partial frame is discarded.
//  FSM states: IDLE, WR1, WR2.
//   IDLE: on accept, latch both samples and addresses into the pair register,
//    then go to WR1.
//   WR1: wr_en=1, wr_addr=adr1, data=sample1. Go to WR2.
//   WR2: wr_en=1, wr_addr=adr2, data=sample2. If a new pair is accepted here,
//    go to WR1. Otherwise go to IDLE.
//  in_ready = (state==IDLE || state==WR2) && !bank_full[wr_bank]
//   && !frame_closing. frame_closing means the WR2 write is sample N of
//   the current frame.
//  Throughput: 1 pair per 2 cycles, sustained. Latency: pair accepted at
//   edge t; sample1 is written at edge t+1 and sample2 at edge t+2.
//  cnt (SIZE+1 bits) increments per write. When the write that makes
//   cnt==N commits, the block does all of the following on the next edge:
//   bank_full[wr_bank]<=1, wr_bank toggles, cnt<=0, done_o=1 for 1 cycle.
//  wr_bank/wr_addr/data remain registered and stable when wr_en=0.
//   wr_en=0 in IDLE.
//  Backpressure: if the target bank is full, in_ready stays 0 and the
//   upstream holds in_valid and its data; nothing is lost.
//  Handoff: frm_valid = bank_full[frm_bank].
//   On frm_ack && frm_valid: clear bank_full[frm_bank] and toggle frm_bank.
//   On frm_ack && !frm_valid: ovf_err<=1. Sticky until rst.
//  Simultaneous: frame completion on bank A and frm_ack on bank B in the same
//   cycle are both applied. The writer never targets a full bank, so a
//   same-bank conflict cannot occur.
//  No address checking: a repeated address within a frame overwrites.
//   The count still advances.
// TESTING
//  1 Reset: hold rst 2 cycles, then release. Expect all outputs 0, then
//    in_ready=1 and wr_bank=0.
//  2 Streaming: N=16, 8 pairs back-to-back (adr 0/1, 2/3, ..., 14/15,
//    data = addr). Expect 16 consecutive wr_en cycles in address order, then
//    done_o pulse, frm_valid=1, frm_bank=0, wr_bank=1.
//  3 Ping-pong stall: fill bank0 and bank1 with no frm_ack. Expect in_ready=0
//    and the 17th pair held. Then pulse frm_ack. Expect bank0 freed, frm_bank=1,
//    writing resumes in bank0 at sample1 of the held pair.
//  4 Gapped input: in_valid every 3rd cycle, adr 0/8, 1/9, ... Expect each
//    write pair at t+1/t+2 with wr_en=0 in the gaps, and done_o after the
//    8th pair.
//  5 Collision: frm_ack for bank0 on the same edge bank1 completes. Expect
//    bank_full=2'b10, frm_bank=1, frm_valid=1, ovf_err=0. Then an extra
//    frm_ack with frm_valid=0 must set ovf_err=1.
//  6 Mid-frame reset: rst after 5 pairs. Expect cnt=0, bank_full=0, wr_bank=0.
//    A new 8-pair frame then completes normally.

Source files
------------

// File: rtl/fft_stage_wr_ctrl.sv
// ---------------------------------------------------------------------------
// fft_stage_wr_ctrl
// Write-side controller for one pipeline FFT stage. Butterfly output pairs
// (two complex samples and their RAM addresses) are accepted through a
// valid/ready handshake and serialised into single-port writes of a
// ping-pong inter-stage RAM. Samples are counted per frame; once a bank holds
// N samples it is marked full, the writer moves to the other bank, and the
// full bank is offered to the next stage through frm_valid/frm_ack.
//
// Ports
//   clk                 clock, all logic on the rising edge
//   rst                 synchronous reset, active-high
//   in_valid/in_ready   butterfly pair handshake
//   in_adr1/in_adr2     RAM addresses of sample 1 / sample 2
//   in_re1/in_im1       sample 1 (signed)
//   in_re2/in_im2       sample 2 (signed)
//   wr_en               RAM write strobe
//   wr_bank             RAM bank being written
//   wr_addr             RAM write address
//   wr_re/wr_im         RAM write data
//   frm_valid           frm_bank holds a complete frame
//   frm_bank            bank offered to the next stage
//   frm_ack             next stage finished reading frm_bank
//   done_o              one-cycle pulse when a frame completes
//   ovf_err             sticky: frm_ack seen while frm_valid low
// ---------------------------------------------------------------------------
module fft_stage_wr_ctrl #(
  parameter int bit_width = 29,
  parameter int N         = 16,
  parameter int SIZE      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic        [SIZE-1:0]      in_adr1,
  input  logic        [SIZE-1:0]      in_adr2,
  input  logic signed [bit_width-1:0] in_re1,
  input  logic signed [bit_width-1:0] in_im1,
  input  logic signed [bit_width-1:0] in_re2,
  input  logic signed [bit_width-1:0] in_im2,
  output logic                        wr_en,
  output logic                        wr_bank,
  output logic        [SIZE-1:0]      wr_addr,
  output logic signed [bit_width-1:0] wr_re,
  output logic signed [bit_width-1:0] wr_im,
  output logic                        frm_valid,
  output logic                        frm_bank,
  input  logic                        frm_ack,
  output logic                        done_o,
  output logic                        ovf_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, WR1 = 2'd1, WR2 = 2'd2} state_t;

  localparam logic [SIZE:0] LAST_CNT = (SIZE+1)'(N - 1);
  localparam logic [SIZE:0] ONE_CNT  = (SIZE+1)'(1);

  state_t r_state;
  state_t w_state_next;

  // Pair register: sample 2 waits here while sample 1 is being written.
  logic        [SIZE-1:0]      r_adr2;
  logic signed [bit_width-1:0] r_re2;
  logic signed [bit_width-1:0] r_im2;

  logic                        r_wr_en;
  logic                        r_wr_bank;
  logic        [SIZE-1:0]      r_wr_addr;
  logic signed [bit_width-1:0] r_wr_re;
  logic signed [bit_width-1:0] r_wr_im;

  logic [SIZE:0] r_cnt;
  logic [1:0]    r_bank_full;
  logic [1:0]    w_bank_full_next;
  logic          r_frm_bank;
  logic          r_done;
  logic          r_ovf_err;

  logic w_writing;
  logic w_frame_done;
  logic w_in_ready;
  logic w_accept;
  logic w_frm_valid;
  logic w_release;

  // A write is on the RAM port in WR1 and WR2; it commits at the closing edge.
  assign w_writing    = (r_state == WR1) || (r_state == WR2);
  // The write currently on the port is sample N of the frame.
  assign w_frame_done = w_writing && (r_cnt == LAST_CNT);

  // No new pair while the frame is closing: the follow-on pair belongs to the
  // other bank, which is only selected once the closing write has committed.
  assign w_in_ready = !rst && ((r_state == IDLE) || (r_state == WR2))
                      && !r_bank_full[r_wr_bank] && !w_frame_done;
  assign w_accept   = in_valid && w_in_ready;

  assign w_frm_valid = r_bank_full[r_frm_bank];
  assign w_release   = frm_ack && w_frm_valid;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = WR1;
      WR1:     w_state_next = WR2;
      WR2:     w_state_next = w_accept ? WR1 : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Completion on the write bank and release of the offered bank can happen
  // on the same edge; they never hit the same bank because the writer never
  // targets a full bank.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      assign w_bank_full_next[gi] =
          (w_frame_done && (r_wr_bank == 1'(gi)))  ? 1'b1 :
          (w_release    && (r_frm_bank == 1'(gi))) ? 1'b0 :
                                                      r_bank_full[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_adr2      <= '0;
      r_re2       <= '0;
      r_im2       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_bank   <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_re     <= '0;
      r_wr_im     <= '0;
      r_cnt       <= '0;
      r_bank_full <= 2'b00;
      r_frm_bank  <= 1'b0;
      r_done      <= 1'b0;
      r_ovf_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_wr_en     <= (w_state_next != IDLE);
      r_bank_full <= w_bank_full_next;

      // Sample 1 goes straight to the write port; sample 2 is parked.
      // Outside these two cases the port registers hold their values.
      if (w_accept) begin
        r_adr2    <= in_adr2;
        r_re2     <= in_re2;
        r_im2     <= in_im2;
        r_wr_addr <= in_adr1;
        r_wr_re   <= in_re1;
        r_wr_im   <= in_im1;
      end else if (r_state == WR1) begin
        r_wr_addr <= r_adr2;
        r_wr_re   <= r_re2;
        r_wr_im   <= r_im2;
      end

      if (w_frame_done) begin
        r_cnt     <= '0;
        r_wr_bank <= ~r_wr_bank;
        r_done    <= 1'b1;
      end else begin
        if (w_writing) r_cnt <= r_cnt + ONE_CNT;
        r_done <= 1'b0;
      end

      if (w_release) r_frm_bank <= ~r_frm_bank;
      if (frm_ack && !w_frm_valid) r_ovf_err <= 1'b1;
    end
  end

  assign in_ready  = w_in_ready;
  assign wr_en     = r_wr_en;
  assign wr_bank   = r_wr_bank;
  assign wr_addr   = r_wr_addr;
  assign wr_re     = r_wr_re;
  assign wr_im     = r_wr_im;
  assign frm_valid = w_frm_valid;
  assign frm_bank  = r_frm_bank;
  assign done_o    = r_done;
  assign ovf_err   = r_ovf_err;

endmodule
